// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared encodings for the EX-stage ALU control unit.
//   - R-type Funct codes decoded by alu_md_ctl
//   - ALUOperation select codes
//   - shiftCtl / mfSel / md_op encodings
//   - 2-bit IDLE/RUN/DONE state enum for the mult/div sequencer
package alu_md_pkg;

  // R-type Funct codes
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // Main-decoder classes
  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_R   = 2'b10;
  localparam logic [1:0] AOP_OR  = 2'b11;

  // ALUOperation select codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // shiftCtl
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  // mfSel
  localparam logic [1:0] MF_ALU = 2'b00;
  localparam logic [1:0] MF_HI  = 2'b01;
  localparam logic [1:0] MF_LO  = 2'b10;

  // md_op (equals Funct[1:0] of the mult-class op)
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_md_seq.sv
// alu_md_seq: IDLE/RUN/DONE sequencer for the multi-cycle mult/div unit.
//   clk, rst_n  : clock, async active-low reset
//   start_req   : accepted start (only honoured in IDLE)
//   md_count    : iteration index, 0..MD_CYCLES-1 while in RUN, 0 otherwise
//   hilo_we     : high for the single DONE cycle
//   busy        : state is RUN or DONE
// Parameters: MD_CYCLES (2..64), CNT_W with 2**CNT_W > MD_CYCLES.
module alu_md_seq
  import alu_md_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  output logic [CNT_W-1:0] md_count,
  output logic             hilo_we,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start_req) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: if (cnt_q == LAST) begin
        state_d = ST_DONE;
        cnt_d   = '0;   // counter reads 0 outside RUN
      end else begin
        cnt_d   = cnt_q + ONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    md_count = cnt_q;
    hilo_we  = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/alu_md_ctl.sv
// alu_md_ctl: EX-stage ALU control. Decodes ALUOp/Funct into ALU, shifter
// and HI/LO-read selects and sequences the multi-cycle mult/div unit.
//   clk, rst_n     : clock, async active-low reset
//   issue          : valid instruction in EX
//   ALUOp, Funct   : main-decoder class and R-type function field
//   ALUOperation   : ALU select (combinational)
//   shiftCtl,mfSel : shifter op / result source (combinational)
//   md_start       : combinational start pulse, md_op latched on it
//   md_count       : iteration index, hilo_we : one-cycle HI/LO write
//   stall          : HI/LO consumer or mult-class op while unit busy
//   illegal_funct  : issued R-type with undecoded Funct
// Build option: define ALU_MD_DIV_EN to let div/divu (26/27) start the
// sequence; otherwise they are reported as illegal.
module alu_md_ctl
  import alu_md_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  output logic [3:0]       ALUOperation,
  output logic [1:0]       shiftCtl,
  output logic [1:0]       mfSel,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic [CNT_W-1:0] md_count,
  output logic             hilo_we,
  output logic             stall,
  output logic             illegal_funct
);

  logic       is_r, known, can_start, md_user, busy;
  logic [1:0] md_op_q, md_op_d;

  // Funct/ALUOp decode
  always_comb begin
    is_r         = (ALUOp == AOP_R);
    ALUOperation = ALU_AND;
    shiftCtl     = SH_NONE;
    mfSel        = MF_ALU;
    known        = 1'b1;
    can_start    = 1'b0;
    case (ALUOp)
      AOP_ADD: ALUOperation = ALU_ADD;
      AOP_SUB: ALUOperation = ALU_SUB;
      AOP_OR:  ALUOperation = ALU_OR;
      default: begin
        case (Funct)
          F_ADD, F_ADDU: ALUOperation = ALU_ADD;
          F_SUB, F_SUBU: ALUOperation = ALU_SUB;
          F_AND:         ALUOperation = ALU_AND;
          F_OR:          ALUOperation = ALU_OR;
          F_XOR:         ALUOperation = ALU_XOR;
          F_NOR:         ALUOperation = ALU_NOR;
          F_SLT:         ALUOperation = ALU_SLT;
          F_SLTU:        ALUOperation = ALU_SLTU;
          F_SLL:         shiftCtl     = SH_SLL;
          F_SRL:         shiftCtl     = SH_SRL;
          F_SRA:         shiftCtl     = SH_SRA;
          F_MFHI:        mfSel        = MF_HI;
          F_MFLO:        mfSel        = MF_LO;
          F_MULT, F_MULTU: can_start  = 1'b1;
`ifdef ALU_MD_DIV_EN
          F_DIV, F_DIVU:   can_start  = 1'b1;
`endif
          default:       known        = 1'b0;
        endcase
      end
    endcase
  end

  // Any op that reads HI/LO or occupies the unit; div codes count here
  // even when division is compiled out.
  always_comb begin
    md_user = is_r && (Funct == F_MFHI || Funct == F_MFLO ||
                       (Funct >= F_MULT && Funct <= F_DIVU));
  end

  // A stalled mult-class op starts on the first IDLE cycle while issue
  // is still held, since busy is the only gate.
  always_comb begin
    md_start      = issue && is_r && can_start && !busy;
    stall         = issue && md_user && busy;
    illegal_funct = issue && is_r && !known;
    md_op_d       = md_start ? Funct[1:0] : md_op_q;
    md_op         = md_op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_op_q <= MD_MULT;
    else        md_op_q <= md_op_d;
  end

  alu_md_seq #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (md_start),
    .md_count  (md_count),
    .hilo_we   (hilo_we),
    .busy      (busy)
  );

endmodule

// File: tb/tb_alu_md_ctl.sv
// Bench for alu_md_ctl: decode vector table, directed multi-cycle
// sequences, then random traffic against a timeline reference model.
module tb_alu_md_ctl;

  localparam int MD = 32;
  localparam int CW = 7;
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk, rst_n, issue;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [3:0]    ALUOperation;
  logic [1:0]    shiftCtl, mfSel, md_op;
  logic          md_start, hilo_we, stall, illegal_funct;
  logic [CW-1:0] md_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_md_ctl #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .ALUOp(ALUOp), .Funct(Funct),
    .ALUOperation(ALUOperation), .shiftCtl(shiftCtl), .mfSel(mfSel),
    .md_start(md_start), .md_op(md_op), .md_count(md_count),
    .hilo_we(hilo_we), .stall(stall), .illegal_funct(illegal_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1, checks at posedge+5.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic [1:0] a, input logic [5:0] f);
    issue = i; ALUOp = a; Funct = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic [1:0] sh;
    logic [1:0] mf;
    logic       ill;
  } vec_t;

  vec_t tbl[22];

  // Reference model state: cycle of last accepted start, latched op.
  int         cyc, ms;
  logic [1:0] mop;
  logic [5:0] fl[8];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 6'd0);
    #3;
    chk("rst_md_count", 32'(md_count), 0);
    chk("rst_md_op",    32'(md_op), 0);
    chk("rst_hilo_we",  32'(hilo_we), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_stall",    32'(stall), 0);
    rst_n = 1'b1;
    tick();

    // ---- decode table (no mult-class entries, so state stays IDLE) ----
    tbl[0]  = '{2'd0, 6'd0,  4'b0010, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'd1, 6'd0,  4'b0110, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{2'd3, 6'd0,  4'b0001, 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{2'd2, 6'd32, 4'b0010, 2'b00, 2'b00, 1'b0};
    tbl[4]  = '{2'd2, 6'd33, 4'b0010, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{2'd2, 6'd34, 4'b0110, 2'b00, 2'b00, 1'b0};
    tbl[6]  = '{2'd2, 6'd35, 4'b0110, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{2'd2, 6'd36, 4'b0000, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{2'd2, 6'd37, 4'b0001, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{2'd2, 6'd38, 4'b0011, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{2'd2, 6'd39, 4'b1100, 2'b00, 2'b00, 1'b0};
    tbl[11] = '{2'd2, 6'd42, 4'b0111, 2'b00, 2'b00, 1'b0};
    tbl[12] = '{2'd2, 6'd43, 4'b1111, 2'b00, 2'b00, 1'b0};
    tbl[13] = '{2'd2, 6'd0,  4'b0000, 2'b01, 2'b00, 1'b0};
    tbl[14] = '{2'd2, 6'd2,  4'b0000, 2'b10, 2'b00, 1'b0};
    tbl[15] = '{2'd2, 6'd3,  4'b0000, 2'b11, 2'b00, 1'b0};
    tbl[16] = '{2'd2, 6'd16, 4'b0000, 2'b00, 2'b01, 1'b0};
    tbl[17] = '{2'd2, 6'd18, 4'b0000, 2'b00, 2'b10, 1'b0};
    tbl[18] = '{2'd2, 6'd1,  4'b0000, 2'b00, 2'b00, 1'b1};
    tbl[19] = '{2'd2, 6'd63, 4'b0000, 2'b00, 2'b00, 1'b1};
    tbl[20] = '{2'd0, 6'd16, 4'b0010, 2'b00, 2'b00, 1'b0};
    tbl[21] = '{2'd3, 6'd3,  4'b0001, 2'b00, 2'b00, 1'b0};
    for (int i = 0; i < 22; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].fn);
      #4;
      chk($sformatf("dec%0d_alu", i), 32'(ALUOperation), 32'(tbl[i].alu));
      chk($sformatf("dec%0d_sh", i),  32'(shiftCtl), 32'(tbl[i].sh));
      chk($sformatf("dec%0d_mf", i),  32'(mfSel), 32'(tbl[i].mf));
      chk($sformatf("dec%0d_ill", i), 32'(illegal_funct), 32'(tbl[i].ill));
      chk($sformatf("dec%0d_stall", i), 32'(stall), 0);
      chk($sformatf("dec%0d_start", i), 32'(md_start), 0);
      tick();
    end

    // ---- mult at T, mflo held from T+5 ----
    drive(1'b1, 2'd2, 6'd24);
    #4;
    chk("mult_start", 32'(md_start), 1);
    chk("mult_stall", 32'(stall), 0);
    tick();
    for (int k = 1; k <= 34; k++) begin
      drive(k >= 5, 2'd2, 6'd18);
      #4;
      if (k <= MD) chk($sformatf("mult_cnt_T%0d", k), 32'(md_count), 32'(k - 1));
      chk($sformatf("mult_hilo_T%0d", k), 32'(hilo_we), 32'(k == MD + 1));
      chk($sformatf("mult_stall_T%0d", k), 32'(stall), 32'(k >= 5 && k <= MD + 1));
      chk($sformatf("mult_nostart_T%0d", k), 32'(md_start), 0);
      if (k == 1)  chk("mult_md_op", 32'(md_op), 0);
      if (k == 34) chk("mflo_mfsel", 32'(mfSel), 2);
      tick();
    end

    // ---- reset mid-RUN ----
    drive(1'b1, 2'd2, 6'd25);
    #4;
    chk("abort_start", 32'(md_start), 1);
    tick();
    drive(1'b0, 2'd2, 6'd0);
    for (int k = 1; k < 10; k++) tick();
    drive(1'b1, 2'd2, 6'd18);
    rst_n = 1'b0;
    #2;
    chk("abort_cnt",   32'(md_count), 0);
    chk("abort_stall", 32'(stall), 0);
    chk("abort_md_op", 32'(md_op), 0);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 2'd2, 6'd0);
    tick();
    for (int k = 0; k < 40; k++) begin
      #4;
      chk($sformatf("abort_nohilo%0d", k), 32'(hilo_we), 0);
      tick();
    end

    // ---- divu ----
    drive(1'b1, 2'd2, 6'd27);
    #4;
    chk("divu_start", 32'(md_start), 32'(DIV_EN));
    chk("divu_ill",   32'(illegal_funct), 32'(!DIV_EN));
    tick();
    drive(1'b0, 2'd2, 6'd0);
    if (DIV_EN) begin
      for (int k = 1; k <= MD + 1; k++) begin
        #4;
        if (k == 1) chk("divu_md_op", 32'(md_op), 3);
        chk($sformatf("divu_hilo_T%0d", k), 32'(hilo_we), 32'(k == MD + 1));
        tick();
      end
    end else begin
      drive(1'b1, 2'd2, 6'd18);
      #4;
      chk("divu_nobusy_stall", 32'(stall), 0);
      chk("divu_md_op", 32'(md_op), 0);
      tick();
      drive(1'b0, 2'd2, 6'd0);
    end

    // ---- multu issued in the DONE cycle ----
    drive(1'b1, 2'd2, 6'd24);
    #4;
    chk("d_mult_start", 32'(md_start), 1);
    tick();
    drive(1'b0, 2'd2, 6'd0);
    for (int k = 1; k <= MD; k++) tick();
    drive(1'b1, 2'd2, 6'd25);
    #4;
    chk("d_done_hilo",  32'(hilo_we), 1);
    chk("d_done_stall", 32'(stall), 1);
    chk("d_done_start", 32'(md_start), 0);
    tick();
    #4;
    chk("d_next_stall", 32'(stall), 0);
    chk("d_next_start", 32'(md_start), 1);
    tick();
    drive(1'b0, 2'd2, 6'd0);
    #4;
    chk("d_md_op",  32'(md_op), 1);
    chk("d_md_cnt", 32'(md_count), 0);
    tick();
    for (int k = 0; k < MD + 2; k++) tick();

    // ---- random traffic vs timeline model ----
    fl = '{6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd0};
    do_reset();
    cyc = 0; ms = -1000; mop = 2'b00;
    for (int r = 0; r < 1500; r++) begin
      logic busy_m, mc, user, e_start;
      logic [1:0] a;
      logic [5:0] f;
      a = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      f = fl[$urandom_range(0, 7)];
      drive($urandom_range(0, 3) != 0, a, f);
      busy_m  = (cyc >= ms + 1) && (cyc <= ms + MD + 1);
      mc      = (a == 2'd2) && (f == 6'd24 || f == 6'd25 ||
                                (DIV_EN && (f == 6'd26 || f == 6'd27)));
      user    = (a == 2'd2) && (f == 6'd16 || f == 6'd18 || (f >= 6'd24 && f <= 6'd27));
      e_start = issue && mc && !busy_m;
      #4;
      chk("rnd_start", 32'(md_start), 32'(e_start));
      chk("rnd_stall", 32'(stall), 32'(issue && user && busy_m));
      chk("rnd_hilo",  32'(hilo_we), 32'(cyc == ms + MD + 1));
      chk("rnd_md_op", 32'(md_op), 32'(mop));
      if (cyc >= ms + 1 && cyc <= ms + MD)
        chk("rnd_cnt", 32'(md_count), 32'(cyc - ms - 1));
      tick();
      if (e_start) begin
        ms  = cyc;
        mop = f[1:0];
      end
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md_ctl.md
# alu_md_ctl

Parametrised ALU control unit for the pipelined core's EX stage. It decodes ALUOp/Funct into ALU, shifter and HI/LO-read selects, and sequences the multi-cycle multiply/divide unit. Its FSM replaces the free-running 33-count multiply counter of the previous generation with a configurable cycle count and an explicit start/done handshake. It raises a stall when a HI/LO consumer or a second mult/div op issues while the unit is busy.

## Interface
- MD_CYCLES, default 32: iteration cycles for mult/multu/div/divu; legal range 2..64.
- CNT_W, default 7: counter width; must satisfy 2^CNT_W > MD_CYCLES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- issue  in  1  valid instruction in EX this cycle.
- ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 R-type, 11 or (ori).
- Funct  in  6  R-type function field.
- ALUOperation  out  4  ALU select.
- shiftCtl  out  2  shifter op: 00 none, 01 sll, 10 srl, 11 sra.
- mfSel  out  2  result source: 00 ALU/shifter, 01 HI, 10 LO.
- md_start  out  1  one-cycle start pulse to the multiply/divide datapath.
- md_op  out  2  registered op latched at start: 00 mult, 01 multu, 10 div, 11 divu.
- md_count  out  CNT_W  iteration index.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- stall  out  1  freeze IF/ID/EX this cycle.
- illegal_funct  out  1  R-type Funct not decoded.

## Operation
- ALUOperation is combinational on ALUOp and Funct:
  - ALUOp 00 → 0010 (add); 01 → 0110 (sub); 11 → 0001 (or).
  - For ALUOp 10: add/addu (32/33) → 0010; sub/subu (34/35) → 0110; and 36 → 0000; or 37 → 0001; xor 38 → 0011; nor 39 → 1100; slt 42 → 0111; sltu 43 → 1111.
  - Any other value → 0000.
- shiftCtl: Funct 0/2/3 with ALUOp 10 → 01/10/11; otherwise 00.
- mfSel: Funct 16 (mfhi) → 01; 18 (mflo) → 10; only when ALUOp 10.
- illegal_funct: ALUOp 10, issue=1, and Funct matches no listed code. Combinational.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on issue & ALUOp 10 & mult-class Funct (24..27). That same cycle drives md_start=1 (combinational), latches md_op, and clears the counter.
  - RUN: md_count increments each cycle from 0. When md_count == MD_CYCLES-1, go to DONE.
  - DONE: hilo_we=1 for exactly one cycle, then go to IDLE.
- stall = issue & ALUOp 10 & (Funct ∈ {16,18,24..27}) & state≠IDLE. It stays low in IDLE, so back-to-back ALU ops never stall.
- A mult-class op that issued while stalled starts on the first IDLE cycle, while issue is still held high.

## Timing
- Reset (async assert, sync release): state IDLE, md_count 0, md_op 00. hilo_we, md_start and stall are 0.
- Start cycle T: md_start=1. RUN occupies T+1..T+MD_CYCLES, with md_count 0..MD_CYCLES-1. DONE at T+MD_CYCLES+1, with hilo_we=1. First non-stalled mfhi is at T+MD_CYCLES+2.
- mfhi/mflo issued in the DONE cycle stalls that one cycle only. HI/LO is written at the end of DONE.
- A new mult issued in the DONE cycle stalls once, then starts in the following IDLE cycle.
- rst_n asserted mid-RUN: the operation is aborted, hilo_we is not pulsed, and the state is IDLE immediately.
- Funct/ALUOp changes during RUN do not affect md_op or md_count.

## Configuration
- ALU_MD_DIV_EN defined: div/divu (26/27) start the sequence as above.
- ALU_MD_DIV_EN undefined: Funct 26/27 do not start the sequence and raise illegal_funct; md_op never takes values 10 or 11.

## Structure
- The shared package alu_md_pkg holds:
  - the Funct code constants;
  - the ALUOperation codes;
  - the shiftCtl/mfSel encodings;
  - the FSM state enum (2-bit).
- One sub-module, alu_md_seq: the IDLE/RUN/DONE FSM plus counter, with ports start_req, md_count, hilo_we and busy.
- Decode logic stays in the top module.

## Test plan
- Reset, then ALUOp 10 with Funct 34 → ALUOperation 0110, stall 0, illegal_funct 0.
- issue mult (24) at T with MD_CYCLES=32:
  - md_start=1 at T;
  - md_count 31 at T+32;
  - hilo_we=1 at T+33 only.
- mflo issued at T+5 and held → stall=1 through T+33, released at T+34 with mfSel=10.
- rst_n low at T+10 mid-RUN → state IDLE, md_count 0, no hilo_we pulse ever for that op.
- divu (27) with ALU_MD_DIV_EN undefined → illegal_funct=1, md_start=0. With the macro defined → md_op=11 and a full sequence.
- multu issued in the DONE cycle → stall=1 for one cycle, md_start=1 the next cycle, md_op=01.
